// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM states, parity modes, bit-rate helpers.
package uart_pkg;

    localparam int DEF_CLK_HZ   = 100_000_000;
    localparam int DEF_BIT_RATE = 9600;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_EVEN = 1;
    localparam int PARITY_ODD  = 2;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_e;

    // Clock cycles per line bit; integer division, no fractional correction.
    function automatic int clks_per_bit(input int clk_hz, input int bit_rate);
        return clk_hz / bit_rate;
    endfunction

    // Counter width for 0..n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 while enabled and strobes on
// the last cycle of each bit. Shared between the UART transmitter and receiver.
module uart_bit_timer
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 10
)(
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_en,
    input  logic i_clr,
    output logic o_tick
);

    localparam int                WIDTH = cnt_width(CLKS_PER_BIT);
    localparam logic [WIDTH-1:0]  LAST  = WIDTH'(CLKS_PER_BIT - 1);

    logic [WIDTH-1:0] r_cnt;
    logic             w_at_last;

    assign w_at_last = (r_cnt == LAST);
    assign o_tick    = i_en && w_at_last;

    // Free-running bit counter; clear wins over enable, wraps at the bit end.
    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= w_at_last ? '0 : r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: 8 data bits LSB first, optional parity, 1 or 2 stop bits,
// valid/ready byte input, registered line output that idles high.
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLK_HZ    = DEF_CLK_HZ,
    parameter int BIT_RATE  = DEF_BIT_RATE,
    parameter int PARITY    = PARITY_NONE,
    parameter int STOP_BITS = 1
)(
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       valid_i,
    output logic       ready_o,
    input  logic [7:0] data_i,
    output logic       tx_o,
    output logic       done_o
);

    localparam int         CLKS_PER_BIT = clks_per_bit(CLK_HZ, BIT_RATE);
    localparam logic [2:0] LAST_STOP    = 3'(STOP_BITS - 1);

    // Reject configurations the frame logic cannot represent.
    generate
        if (PARITY < PARITY_NONE || PARITY > PARITY_ODD) begin : g_bad_parity
            $error("uart_tx: PARITY must be 0, 1 or 2");
        end
        if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
            $error("uart_tx: STOP_BITS must be 1 or 2");
        end
        if (CLKS_PER_BIT < 1) begin : g_bad_rate
            $error("uart_tx: BIT_RATE exceeds CLK_HZ");
        end
    endgenerate

    uart_state_e r_state, w_state_next;
    logic [7:0]  r_shift, w_shift_next;
    logic [2:0]  r_bit_cnt, w_bit_cnt_next;
    logic        r_par, w_par_next;
    logic        r_tx, w_tx_next;
    logic        r_done, w_done_next;
    logic        w_tick;
    logic        w_idle;

    assign w_idle  = (r_state == ST_IDLE);
    assign ready_o = w_idle;
    assign tx_o    = r_tx;
    assign done_o  = r_done;

    uart_bit_timer #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_timer (
        .i_clk  (clk_i),
        .i_rst  (reset_i),
        .i_en   (!w_idle),
        .i_clr  (w_idle),
        .o_tick (w_tick)
    );

    // Next-state, shifter, bit counter and next line level for every state.
    always_comb begin
        w_state_next   = r_state;
        w_shift_next   = r_shift;
        w_par_next     = r_par;
        w_bit_cnt_next = r_bit_cnt;
        w_done_next    = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (valid_i) begin
                    w_state_next = ST_START;
                    w_shift_next = data_i;
                    w_par_next   = (PARITY == PARITY_ODD) ? ~^data_i : ^data_i;
                end
            end
            ST_START: begin
                if (w_tick) w_state_next = ST_DATA;
            end
            ST_DATA: begin
                if (w_tick) begin
                    w_shift_next = {1'b0, r_shift[7:1]};
                    if (r_bit_cnt == 3'd7)
                        w_state_next = (PARITY != PARITY_NONE) ? ST_PARITY : ST_STOP;
                    else
                        w_bit_cnt_next = r_bit_cnt + 3'd1;
                end
            end
            ST_PARITY: begin
                if (w_tick) w_state_next = ST_STOP;
            end
            ST_STOP: begin
                if (w_tick) begin
                    if (r_bit_cnt == LAST_STOP) begin
                        w_state_next = ST_IDLE;
                        w_done_next  = 1'b1;
                    end else begin
                        w_bit_cnt_next = r_bit_cnt + 3'd1;
                    end
                end
            end
            default: w_state_next = ST_IDLE;
        endcase

        // Bit counter restarts in every new state.
        if (w_state_next != r_state) w_bit_cnt_next = 3'd0;

        // Line level is computed for the state being entered so tx_o is a
        // plain register aligned with the state register.
        case (w_state_next)
            ST_START:  w_tx_next = 1'b0;
            ST_DATA:   w_tx_next = w_shift_next[0];
            ST_PARITY: w_tx_next = w_par_next;
            default:   w_tx_next = 1'b1;
        endcase
    end

    // State and datapath registers; reset aborts any frame in flight.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state   <= ST_IDLE;
            r_shift   <= 8'd0;
            r_bit_cnt <= 3'd0;
            r_par     <= 1'b0;
            r_tx      <= 1'b1;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_shift   <= w_shift_next;
            r_bit_cnt <= w_bit_cnt_next;
            r_par     <= w_par_next;
            r_tx      <= w_tx_next;
            r_done    <= w_done_next;
        end
    end

endmodule
